// File: rtl/layer3_window_gen.sv
`default_nettype none
//============================================================================
// Module      : layer3_window_gen
// Description : Streaming 3x3 window generator for the layer-3 convolution
//               stage. Takes a raster-order pixel stream (one pixel per
//               accepted beat) and emits one complete 3x3 window for every
//               accepted pixel at row >= 2 and col >= 2 (valid convolution,
//               no padding). The two row-length line buffers and the window
//               registers advance only on accepted beats.
// Ports       : clk        - clock, rising-edge
//               rst        - asynchronous active-high reset
//               in_data    - pixel beat (all channels), raster order
//               in_valid   - in_data valid
//               in_ready   - block can accept a beat (0 while rst high)
//               win_data   - 3x3 window; slice [DATA_W*(3*r+c) +: DATA_W]
//                            is row r (0 = top/oldest), column c (0 = left)
//               out_valid  - win_data holds a complete window
//               out_ready  - consumer takes the window
//               frame_done - one-cycle pulse after the last pixel of a frame
// Revision    : 1.0 - initial release
//============================================================================
module layer3_window_gen #(
   parameter int DATA_W = 128,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [9*DATA_W-1:0]   win_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_done
);

   localparam int c_col_w = $clog2(IMG_W);
   localparam int c_row_w = $clog2(IMG_H);

   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
   localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
   localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);
   localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);
   localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);

   // Line buffers: entry 0 is the newest pixel, entry IMG_W-1 (the tail)
   // is the pixel accepted IMG_W beats earlier, i.e. the one directly above.
   logic [DATA_W-1:0]  r_lb1 [IMG_W];
   logic [DATA_W-1:0]  r_lb2 [IMG_W];
   logic [DATA_W-1:0]  r_win [3][3];
   logic [c_col_w-1:0] r_col;
   logic [c_row_w-1:0] r_row;
   logic               r_out_valid;
   logic               r_frame_done;

   logic w_accept;
   logic w_last_col;
   logic w_last_pix;
   logic w_hit;

   // A pending window blocks new input unless it is being consumed now,
   // which keeps win_data stable while the consumer stalls.
   assign in_ready   = !rst && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_last_col = (r_col == c_col_last);
   assign w_last_pix = w_last_col && (r_row == c_row_last);
   assign w_hit      = w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);

   assign out_valid  = r_out_valid;
   assign frame_done = r_frame_done;

   // Line buffers and window registers; right column is sampled from the
   // buffer tails before they shift.
   always_ff @(posedge clk or posedge rst) begin : p_data
      if (rst) begin
         for (int i = 0; i < IMG_W; i++) begin
            r_lb1[i] <= '0;
            r_lb2[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (w_accept) begin
         r_lb1[0] <= in_data;
         r_lb2[0] <= r_lb1[IMG_W-1];
         for (int i = 1; i < IMG_W; i++) begin
            r_lb1[i] <= r_lb1[i-1];
            r_lb2[i] <= r_lb2[i-1];
         end
         for (int r = 0; r < 3; r++) begin
            r_win[r][0] <= r_win[r][1];
            r_win[r][1] <= r_win[r][2];
         end
         r_win[2][2] <= in_data;
         r_win[1][2] <= r_lb1[IMG_W-1];
         r_win[0][2] <= r_lb2[IMG_W-1];
      end
   end

   // Raster position counters and output handshake flops.
   always_ff @(posedge clk or posedge rst) begin : p_ctrl
      if (rst) begin
         r_col        <= '0;
         r_row        <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_accept && w_last_pix;
         if (w_hit) begin
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_last_col) begin
               r_col <= '0;
               r_row <= (r_row == c_row_last) ? '0 : r_row + c_row_one;
            end else begin
               r_col <= r_col + c_col_one;
            end
         end
      end
   end

   for (genvar gr = 0; gr < 3; gr++) begin : g_win_row
      for (genvar gc = 0; gc < 3; gc++) begin : g_win_col
         assign win_data[DATA_W*(3*gr+gc) +: DATA_W] = r_win[gr][gc];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_layer3_window_gen.sv
`default_nettype none
//============================================================================
// Module      : tb_layer3_window_gen
// Description : Self-checking bench for layer3_window_gen. Two instances:
//               4x4 frame (dut_a) and 5x3 frame (dut_b), DATA_W = 16. The
//               reference model keeps the accepted pixels of the current
//               frame in an array and builds each expected window directly
//               from image coordinates; a queue holds windows produced but
//               not yet taken by the consumer.
// Revision    : 1.0 - initial release
//============================================================================
module tb_layer3_window_gen;

   localparam int c_dw = 16;
   localparam int c_ww = 9 * c_dw;

   logic clk;
   logic rst;

   logic [c_dw-1:0] a_in_data, b_in_data;
   logic            a_in_valid, b_in_valid;
   logic            a_in_ready, b_in_ready;
   logic [c_ww-1:0] a_win, b_win;
   logic            a_out_valid, b_out_valid;
   logic            a_out_ready, b_out_ready;
   logic            a_fd, b_fd;

   layer3_window_gen #(.DATA_W(c_dw), .IMG_W(4), .IMG_H(4)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .in_data    (a_in_data),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .win_data   (a_win),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
      .frame_done (a_fd)
   );

   layer3_window_gen #(.DATA_W(c_dw), .IMG_W(5), .IMG_H(3)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .in_data    (b_in_data),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .win_data   (b_win),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
      .frame_done (b_fd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counters and model state
   int              vectors     = 0;
   int              miscompares = 0;
   bit              sel         = 1'b0;
   int              img_w       = 4;
   int              img_h       = 4;
   int              k           = 0;
   bit              rnd_data    = 1'b0;
   bit              fd_exp      = 1'b0;
   bit              last_acc    = 1'b0;
   int              fd_cnt      = 0;
   logic [c_dw-1:0] cur         = '0;
   logic [c_dw-1:0] fpix [64];
   logic [c_ww-1:0] exp_q [$];
   logic [c_ww-1:0] wlog [$];
   logic [c_ww-1:0] ref_log [$];

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0b expected %0b", tag, got, exp);
      end
   endtask

   task automatic chk_win(input string tag, input logic [c_ww-1:0] got, input logic [c_ww-1:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Window whose bottom-right pixel sits at image position (r, c).
   function automatic logic [c_ww-1:0] win_of(input int r, input int c);
      logic [c_ww-1:0] w;
      w = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            w[c_dw*(3*i+j) +: c_dw] = fpix[(r-2+i)*img_w + (c-2+j)];
      return w;
   endfunction

   function automatic logic [c_ww-1:0] log_at(input int i);
      return (i < wlog.size()) ? wlog[i] : '0;
   endfunction

   // One clock cycle: drive at the falling edge, check registered outputs,
   // update the model according to the handshakes that will happen at the
   // following rising edge.
   task automatic cycle(input bit v, input bit ordy);
      logic            ir, ov, fd;
      logic [c_ww-1:0] wd;
      bit              acc, cons;
      int              r, c;
      @(negedge clk);
      if (sel == 1'b0) begin
         a_in_valid = v; a_in_data = cur; a_out_ready = ordy;
      end else begin
         b_in_valid = v; b_in_data = cur; b_out_ready = ordy;
      end
      #1;
      ir = sel ? b_in_ready  : a_in_ready;
      ov = sel ? b_out_valid : a_out_valid;
      fd = sel ? b_fd        : a_fd;
      wd = sel ? b_win       : a_win;
      chk_bit("out_valid", ov, exp_q.size() != 0);
      chk_bit("in_ready", ir, (exp_q.size() == 0) || ordy);
      chk_bit("frame_done", fd, fd_exp);
      if (exp_q.size() != 0) chk_win("win_data", wd, exp_q[0]);
      if (fd) fd_cnt++;
      cons = ov && ordy;
      acc  = v && ir;
      if (cons && exp_q.size() != 0) begin
         void'(exp_q.pop_front());
         wlog.push_back(wd);
      end
      fd_exp = 1'b0;
      if (acc) begin
         fpix[k] = cur;
         r = k / img_w;
         c = k % img_w;
         if (r >= 2 && c >= 2) exp_q.push_back(win_of(r, c));
         if (k == img_w*img_h - 1) begin
            fd_exp   = 1'b1;
            last_acc = 1'b1;
            k        = 0;
         end else begin
            k++;
         end
         cur = rnd_data ? c_dw'($urandom) : c_dw'(k);
      end
      @(posedge clk);
   endtask

   task automatic check_idle_outputs();
      chk_bit("rst_in_ready_a", a_in_ready, 1'b0);
      chk_bit("rst_out_valid_a", a_out_valid, 1'b0);
      chk_bit("rst_frame_done_a", a_fd, 1'b0);
      chk_win("rst_win_a", a_win, '0);
      chk_bit("rst_in_ready_b", b_in_ready, 1'b0);
      chk_bit("rst_out_valid_b", b_out_valid, 1'b0);
      chk_win("rst_win_b", b_win, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
      #1;
      check_idle_outputs();
      @(negedge clk);
      #1;
      check_idle_outputs();
      @(negedge clk);
      rst = 1'b0;
      k = 0; fd_exp = 1'b0; last_acc = 1'b0;
      exp_q.delete();
      cur = rnd_data ? c_dw'($urandom) : '0;
   endtask

   // Run until the current frame's last pixel is in and every window taken.
   task automatic run_frame(input int pv, input int pr);
      int n;
      last_acc = 1'b0;
      fd_cnt   = 0;
      wlog.delete();
      n = 0;
      while (!(last_acc && exp_q.size() == 0) && n < 1000) begin
         cycle(!last_acc && ($urandom_range(99) < pv), $urandom_range(99) < pr);
         n++;
      end
      cycle(1'b0, 1'b1);
      chk_bit("frame_timeout", n < 1000, 1'b1);
      chk_int("frame_done_pulses", fd_cnt, 1);
      chk_int("window_count", wlog.size(), (img_w-2)*(img_h-2));
   endtask

   task automatic compare_ref(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk_win(tag, log_at(i), (i < ref_log.size()) ? ref_log[i] : '0);
      end
   endtask

   initial begin
      int n;
      int k0;
      rst = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

      // Reset state and basic 4x4 raster frame
      do_reset();
      run_frame(100, 100);
      chk_win("first_window", log_at(0),
              {16'd10, 16'd9, 16'd8, 16'd6, 16'd5, 16'd4, 16'd2, 16'd1, 16'd0});
      chk_win("last_window", log_at(3),
              {16'd15, 16'd14, 16'd13, 16'd11, 16'd10, 16'd9, 16'd7, 16'd6, 16'd5});
      ref_log = wlog;

      // Second frame back to back: same window sequence
      run_frame(100, 100);
      compare_ref("frame2_window");

      // Backpressure: stall the consumer while the first window is pending
      n = 0;
      while (exp_q.size() == 0 && n < 50) begin
         cycle(1'b1, 1'b1);
         n++;
      end
      chk_bit("bp_window_pending", exp_q.size() != 0, 1'b1);
      k0 = k;
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      chk_int("bp_counter_hold", k, k0);
      run_frame(100, 100);
      compare_ref("bp_window");

      // Input bubbles with raster data
      run_frame(50, 100);
      compare_ref("bubble_window");

      // Random data, random bubbles and random consumer stalls
      rnd_data = 1'b1;
      cur = c_dw'($urandom);
      run_frame(50, 60);
      run_frame(70, 40);
      rnd_data = 1'b0;

      // Reset after 9 accepted pixels of a frame
      do_reset();
      n = 0;
      while (k != 9 && n < 100) begin
         cycle(1'b1, 1'b1);
         n++;
      end
      chk_int("pre_reset_accepts", k, 9);
      do_reset();
      run_frame(100, 100);
      compare_ref("post_reset_window");

      // Non-square 5x3 frame
      sel = 1'b1; img_w = 5; img_h = 3;
      do_reset();
      run_frame(100, 100);
      chk_win("ns_window0", log_at(0),
              {16'd12, 16'd11, 16'd10, 16'd7, 16'd6, 16'd5, 16'd2, 16'd1, 16'd0});
      chk_win("ns_window1", log_at(1),
              {16'd13, 16'd12, 16'd11, 16'd8, 16'd7, 16'd6, 16'd3, 16'd2, 16'd1});
      chk_win("ns_window2", log_at(2),
              {16'd14, 16'd13, 16'd12, 16'd9, 16'd8, 16'd7, 16'd4, 16'd3, 16'd2});
      run_frame(40, 70);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
